uart_line_assembler: RTL and testbench
======================================

# uart_line_assembler

Line-editing stage between the RX FIFO master port and the TX FIFO slave port of the UART echo path. It accepts received bytes over AXI-Stream and assembles them into a line buffer, applying backspace editing. On a line terminator it emits the completed line followed by CR LF. It also reports per-line length, overflow, and a completed-line count for LED/debug use.

## Interface
- DEPTH, 64, line buffer capacity in bytes; power of two, 2..256.
- CW, clog2(DEPTH)+1, width of the character counter; derived, not overridden.
- aclk  in  1  single clock; all logic rising-edge.
- aresetn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- s_axis_tdata  in  8  received byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  block can accept a byte (registered).
- m_axis_tdata  out  8  output byte to TX FIFO (registered).
- m_axis_tvalid  out  1  output byte valid (registered).
- m_axis_tready  in  1  downstream accepts.
- line_len  out  CW  characters currently stored (0..DEPTH).
- line_overflow  out  1  sticky: at least one byte dropped in the current line.
- lines_done  out  8  count of lines fully emitted; wraps 255->0.

## Operation
- States: COLLECT, EMIT, EMIT_CR, EMIT_LF. Reset state is COLLECT.
- COLLECT: s_axis_tready=1. Each accepted byte (tvalid&tready) is classified:
  - 0x0A with last_was_cr=1: consumed, no effect, last_was_cr<=0 (CRLF collapses to one terminator).
  - 0x0D or 0x0A otherwise: terminator. last_was_cr<=(byte==0x0D). Go to EMIT if line_len>0, else EMIT_CR. s_axis_tready<=0.
  - 0x08 or 0x7F: line_len decrements if >0, else no effect. last_was_cr<=0.
  - Any other byte: stored at buf[line_len], line_len+1 if line_len<DEPTH. Otherwise dropped and line_overflow<=1. last_was_cr<=0.
- EMIT: present buf[rd_idx] for rd_idx=0..line_len-1, one byte per accepted transfer. After the last byte is accepted, go to EMIT_CR.
- EMIT_CR: present 0x0D; on acceptance go to EMIT_LF.
- EMIT_LF: present 0x0A; on acceptance:
  - line_len<=0, rd_idx<=0, line_overflow<=0
  - lines_done+1 (mod 256)
  - go to COLLECT, s_axis_tready<=1
- No input is accepted outside COLLECT. Upstream data waits in the RX FIFO.
- Buffer contents are not cleared on reset or line completion; only line_len is.

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0x00, line_len=0, line_overflow=0, lines_done=0, last_was_cr=0. s_axis_tready rises on the first aclk edge after aresetn deasserts.
- Input throughput: one byte per cycle while in COLLECT.
- Output latency: terminator accepted at edge N gives m_axis_tvalid=1 from edge N+1, carrying buf[0] (or 0x0D for an empty line).
- Output throughput: one byte per cycle while m_axis_tready=1. A line of L characters occupies L+2 transfers.
- AXI-S rules:
  - Once m_axis_tvalid=1, it and m_axis_tdata hold until m_axis_tready=1.
  - tvalid never depends combinationally on tready.
  - m_axis_tvalid drops the cycle after the LF is accepted.
  - s_axis_tready drops the cycle after a terminator is accepted and rises the cycle after the LF is accepted.
- Buffer read: the registered output must prefetch so back-to-back transfers have no bubble.
- Reset asserted mid-line or mid-emit: all state returns to reset values immediately. Any partial output is abandoned; m_axis_tvalid deasserts asynchronously.
- line_len reflects the updated value the cycle after an accepted byte.

## Test plan
- Reset then "AB"+0x0D with m_axis_tready=1 -> output 0x41,0x42,0x0D,0x0A; first tvalid one cycle after CR accepted; lines_done=1, line_len=0.
- "AB"+0x0D+0x0A+"C"+0x0A -> output "AB",CR,LF then "C",CR,LF; the LF following CR produces no empty line; lines_done=2.
- "ABC",0x08,0x7F,"X",0x0D -> output 0x41,0x58,0x0D,0x0A. A backspace on an empty line leaves line_len=0.
- DEPTH=4, "ABCDEF"+0x0D -> line_overflow=1 after the 5th byte; output "ABCD",CR,LF; line_overflow=0 after LF.
- Random m_axis_tready stalls on a 10-byte line -> tdata stable while stalled, no loss or duplication; s_axis_tready=0 throughout emit.
- aresetn pulsed low during EMIT of byte 2 -> all outputs return to reset values; a subsequent "Z"+0x0D yields exactly 0x5A,0x0D,0x0A.

Source files
------------

// File: rtl/uart_line_assembler.sv
// Line editor for the UART echo path: collects bytes with backspace editing,
// then replays the finished line followed by CR LF.
module uart_line_assembler #(
  parameter  int DEPTH = 64,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [7:0]    m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [CW-1:0] line_len,
  output logic          line_overflow,
  output logic [7:0]    lines_done
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_EMIT    = 2'd1;
  localparam logic [1:0] S_EMIT_CR = 2'd2;
  localparam logic [1:0] S_EMIT_LF = 2'd3;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [1:0]    r_state;
  logic [7:0]    r_buf [DEPTH];
  logic [CW-1:0] r_line_len;
  logic [CW-1:0] r_rd_idx;
  logic          r_last_was_cr;
  logic          r_overflow;
  logic          r_s_tready;
  logic          r_m_tvalid;
  logic [7:0]    r_m_tdata;
  logic [7:0]    r_lines_done;

  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_is_term;
  logic       w_is_bs;
  logic       w_crlf;
  logic       w_store;
  logic [7:0] w_rd_data;

  assign w_in_fire  = s_axis_tvalid & r_s_tready & (r_state == S_COLLECT);
  assign w_out_fire = r_m_tvalid & m_axis_tready;
  assign w_is_term  = (s_axis_tdata == 8'h0D) | (s_axis_tdata == 8'h0A);
  assign w_is_bs    = (s_axis_tdata == 8'h08) | (s_axis_tdata == 8'h7F);
  assign w_crlf     = (s_axis_tdata == 8'h0A) & r_last_was_cr;
  assign w_store    = w_in_fire & ~w_is_term & ~w_is_bs & (r_line_len != DEPTH_C);
  assign w_rd_data  = r_buf[r_rd_idx[CW-2:0]];

  // Line storage has no reset; only the length register defines valid content.
  always_ff @(posedge aclk) begin
    if (w_store) r_buf[r_line_len[CW-2:0]] <= s_axis_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_COLLECT;
      r_line_len    <= '0;
      r_rd_idx      <= '0;
      r_last_was_cr <= 1'b0;
      r_overflow    <= 1'b0;
      r_s_tready    <= 1'b0;
      r_m_tvalid    <= 1'b0;
      r_m_tdata     <= 8'h00;
      r_lines_done  <= 8'h00;
    end else begin
      case (r_state)
        S_COLLECT: begin
          r_s_tready <= 1'b1;
          if (w_in_fire) begin
            if (w_crlf) begin
              r_last_was_cr <= 1'b0;
            end else if (w_is_term) begin
              // Output register is preloaded here so the first byte leaves next cycle.
              r_last_was_cr <= (s_axis_tdata == 8'h0D);
              r_s_tready    <= 1'b0;
              r_m_tvalid    <= 1'b1;
              if (r_line_len != '0) begin
                r_state   <= S_EMIT;
                r_m_tdata <= r_buf[0];
                r_rd_idx  <= ONE_C;
              end else begin
                r_state   <= S_EMIT_CR;
                r_m_tdata <= 8'h0D;
              end
            end else if (w_is_bs) begin
              r_last_was_cr <= 1'b0;
              if (r_line_len != '0) r_line_len <= r_line_len - ONE_C;
            end else begin
              r_last_was_cr <= 1'b0;
              if (r_line_len != DEPTH_C) r_line_len <= r_line_len + ONE_C;
              else                       r_overflow <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (w_out_fire) begin
            if (r_rd_idx == r_line_len) begin
              r_m_tdata <= 8'h0D;
              r_state   <= S_EMIT_CR;
            end else begin
              r_m_tdata <= w_rd_data;
              r_rd_idx  <= r_rd_idx + ONE_C;
            end
          end
        end
        S_EMIT_CR: begin
          if (w_out_fire) begin
            r_m_tdata <= 8'h0A;
            r_state   <= S_EMIT_LF;
          end
        end
        default: begin
          if (w_out_fire) begin
            r_m_tvalid   <= 1'b0;
            r_line_len   <= '0;
            r_rd_idx     <= '0;
            r_overflow   <= 1'b0;
            r_lines_done <= r_lines_done + 8'd1;
            r_s_tready   <= 1'b1;
            r_state      <= S_COLLECT;
          end
        end
      endcase
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign line_len      = r_line_len;
  assign line_overflow = r_overflow;
  assign lines_done    = r_lines_done;

endmodule

// File: tb/tb_uart_line_assembler.sv
// Directed bench for uart_line_assembler: a DEPTH=64 instance for the main
// line/edit/stall/reset cases and a DEPTH=4 instance for overflow.
module tb_uart_line_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0] s_tdata, m_tdata, lines_done;
  logic       s_tvalid, s_tready, m_tvalid, m_tready, ovf;
  logic [6:0] line_len;

  logic [7:0] s4_tdata, m4_tdata, lines_done4;
  logic       s4_tvalid, s4_tready, m4_tvalid, m4_tready, ovf4;
  logic [2:0] line_len4;

  uart_line_assembler #(.DEPTH(64)) u_dut (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .line_len(line_len), .line_overflow(ovf), .lines_done(lines_done)
  );

  uart_line_assembler #(.DEPTH(4)) u_dut4 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(s4_tdata), .s_axis_tvalid(s4_tvalid), .s_axis_tready(s4_tready),
    .m_axis_tdata(m4_tdata), .m_axis_tvalid(m4_tvalid), .m_axis_tready(m4_tready),
    .line_len(line_len4), .line_overflow(ovf4), .lines_done(lines_done4)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] q4[$];

  always @(posedge clk) begin
    if (m_tvalid && m_tready)   q.push_back(m_tdata);
    if (m4_tvalid && m4_tready) q4.push_back(m4_tdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    int n = 0;
    if (sel) begin s4_tdata = b; s4_tvalid = 1'b1; end
    else     begin s_tdata  = b; s_tvalid  = 1'b1; end
    while (((sel ? s4_tready : s_tready) !== 1'b1) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("send_timeout", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    s_tvalid  = 1'b0;
    s4_tvalid = 1'b0;
  endtask

  task automatic wait_out(input bit sel, input int n);
    int c = 0;
    while (((sel ? q4.size() : q.size()) < n) && c < 300) begin
      @(posedge clk); #1; c++;
    end
    chk("out_timeout", 32'(c < 300), 32'd1);
  endtask

  task automatic check_q(input bit sel, input string tag, input logic [7:0] e[$]);
    logic [7:0] got[$];
    if (sel) got = q4; else got = q;
    chk({tag, "_count"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++) chk(tag, got[i], e[i]);
    if (sel) q4.delete(); else q.delete();
  endtask

  initial begin
    logic [7:0]  exp[$];
    logic [15:0] pat;
    logic        pv, pr;
    logic [7:0]  pd;
    pat = 16'b1011_0010_1101_0110;

    rst_n = 1'b0;
    s_tdata = 8'h00; s_tvalid = 1'b0; m_tready = 1'b1;
    s4_tdata = 8'h00; s4_tvalid = 1'b0; m4_tready = 1'b1;
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 8'h00);
    chk("rst_line_len", line_len, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_lines_done", lines_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("tready_before_edge", s_tready, 0);
    @(posedge clk); #1;
    chk("tready_after_edge", s_tready, 1);

    // "AB" CR with latency check
    send(0, 8'h41);
    send(0, 8'h42);
    chk("len_after_AB", line_len, 2);
    send(0, 8'h0D);
    chk("first_tvalid", m_tvalid, 1);
    chk("first_tdata", m_tdata, 8'h41);
    chk("tready_low_emit", s_tready, 0);
    wait_out(0, 4);
    exp = '{8'h41, 8'h42, 8'h0D, 8'h0A};
    check_q(0, "line_AB", exp);
    chk("done_1", lines_done, 1);
    chk("len_cleared", line_len, 0);
    chk("tvalid_dropped", m_tvalid, 0);
    chk("tready_back", s_tready, 1);

    // CRLF collapse, then LF-only terminator
    send(0, 8'h41); send(0, 8'h42); send(0, 8'h0D); send(0, 8'h0A);
    send(0, 8'h43); send(0, 8'h0A);
    wait_out(0, 7);
    repeat (4) @(posedge clk);
    #1;
    exp = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h43, 8'h0D, 8'h0A};
    check_q(0, "crlf_collapse", exp);
    chk("done_3", lines_done, 3);

    // Backspace editing
    send(0, 8'h41); send(0, 8'h42); send(0, 8'h43);
    send(0, 8'h08);
    chk("len_after_bs", line_len, 2);
    send(0, 8'h7F);
    chk("len_after_del", line_len, 1);
    send(0, 8'h58); send(0, 8'h0D);
    wait_out(0, 4);
    exp = '{8'h41, 8'h58, 8'h0D, 8'h0A};
    check_q(0, "line_edit", exp);
    send(0, 8'h08);
    chk("bs_empty_len", line_len, 0);

    // Empty line
    send(0, 8'h0D);
    chk("empty_tvalid", m_tvalid, 1);
    chk("empty_tdata", m_tdata, 8'h0D);
    wait_out(0, 2);
    exp = '{8'h0D, 8'h0A};
    check_q(0, "empty_line", exp);
    chk("done_5", lines_done, 5);

    // 10-byte line with downstream stalls
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) send(0, 8'h30 + 8'(i));
    send(0, 8'h0D);
    for (int i = 0; i < 80; i++) begin
      m_tready = pat[i % 16];
      pv = m_tvalid; pd = m_tdata; pr = m_tready;
      @(posedge clk); #1;
      if (pv && !pr) begin
        chk("stall_tvalid_hold", m_tvalid, 1);
        chk("stall_tdata_hold", m_tdata, pd);
      end
      if (m_tvalid) chk("stall_tready_low", s_tready, 0);
    end
    m_tready = 1'b1;
    wait_out(0, 12);
    exp.delete();
    for (int i = 0; i < 10; i++) exp.push_back(8'h30 + 8'(i));
    exp.push_back(8'h0D); exp.push_back(8'h0A);
    check_q(0, "stall_line", exp);
    chk("done_6", lines_done, 6);

    // Reset while the second byte of a line is presented
    send(0, 8'h50); send(0, 8'h51); send(0, 8'h52); send(0, 8'h0D);
    @(posedge clk); #1;
    chk("pre_reset_byte2", m_tdata, 8'h51);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_tdata", m_tdata, 8'h00);
    chk("midrst_tready", s_tready, 0);
    chk("midrst_len", line_len, 0);
    chk("midrst_done", lines_done, 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_tready", s_tready, 1);
    send(0, 8'h5A); send(0, 8'h0D);
    wait_out(0, 3);
    repeat (3) @(posedge clk);
    #1;
    exp = '{8'h5A, 8'h0D, 8'h0A};
    check_q(0, "after_reset", exp);
    chk("done_after_reset", lines_done, 1);

    // Overflow on the DEPTH=4 instance
    send(1, 8'h41); send(1, 8'h42); send(1, 8'h43); send(1, 8'h44);
    chk("ovf4_len_full", line_len4, 4);
    chk("ovf4_clear_at_full", ovf4, 0);
    send(1, 8'h45);
    chk("ovf4_set", ovf4, 1);
    chk("ovf4_len_hold", line_len4, 4);
    send(1, 8'h46); send(1, 8'h0D);
    chk("ovf4_sticky_emit", ovf4, 1);
    wait_out(1, 6);
    exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    check_q(1, "ovf4_line", exp);
    chk("ovf4_cleared", ovf4, 0);
    chk("ovf4_done", lines_done4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
